// File: rtl/seq_divider_if.sv
// Operand/result bundle between the control unit and the sequential divider.
// Handshake: start is a request sampled only while the divider is idle (no ready
// signal; requests while busy are dropped), and done is a one-cycle valid pulse
// for quotient/remainder/div_by_zero, which then hold until the next result.
interface seq_divider_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             signed_op;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             busy;
  logic             done;
  logic             div_by_zero;

  modport master (
    output start, signed_op, dividend, divisor,
    input  quotient, remainder, busy, done, div_by_zero
  );

  modport slave (
    input  start, signed_op, dividend, divisor,
    output quotient, remainder, busy, done, div_by_zero
  );
endinterface

// File: rtl/seq_divider.sv
// Radix-2 restoring divider for the div instruction: one quotient bit per cycle on
// operand magnitudes, then a sign fix-up step (truncating division).
module seq_divider #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic         clock,
  input  logic         clear_n,
  seq_divider_if.slave bus,
  output logic [1:0]   state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ITER  = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] dvs_r;
  logic [CNT_W-1:0] cnt;
  logic             neg_q;
  logic             neg_r;

  logic             zero_div;
  logic             neg_a;
  logic             neg_b;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;

  assign zero_div = (bus.divisor == '0);
  assign neg_a    = bus.signed_op & bus.dividend[WIDTH-1];
  assign neg_b    = bus.signed_op & bus.divisor[WIDTH-1];
  assign mag_a    = neg_a ? -bus.dividend : bus.dividend;
  assign mag_b    = neg_b ? -bus.divisor  : bus.divisor;

  // The most negative value maps onto itself, which is the right unsigned magnitude.
  assign shifted  = {rem_r, quo_r[WIDTH-1]};
  assign trial    = shifted - {1'b0, dvs_r};

  assign state_dbg = state;

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    bus.busy   = 1'b0;
    bus.done   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_next = zero_div ? DONE : ITER;
        end
      end
      ITER: begin
        bus.busy = 1'b1;
        if (cnt == CNT_W'(1)) begin
          state_next = FIXUP;
        end
      end
      FIXUP: begin
        bus.busy   = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        bus.done   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      rem_r           <= '0;
      quo_r           <= '0;
      dvs_r           <= '0;
      cnt             <= '0;
      neg_q           <= 1'b0;
      neg_r           <= 1'b0;
      bus.quotient    <= '0;
      bus.remainder   <= '0;
      bus.div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            rem_r           <= '0;
            quo_r           <= mag_a;
            dvs_r           <= mag_b;
            cnt             <= CNT_W'(WIDTH);
            neg_r           <= neg_a;
            neg_q           <= neg_a ^ neg_b;
            bus.div_by_zero <= zero_div;
            // Zero divisor skips the iterations and reports the raw dividend.
            if (zero_div) begin
              bus.quotient  <= '1;
              bus.remainder <= bus.dividend;
            end
          end
        end
        ITER: begin
          cnt   <= cnt - CNT_W'(1);
          rem_r <= trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
          quo_r <= {quo_r[WIDTH-2:0], ~trial[WIDTH]};
        end
        FIXUP: begin
          bus.quotient  <= neg_q ? -quo_r : quo_r;
          bus.remainder <= neg_r ? -rem_r : rem_r;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: directed corner cases, start-while-busy, mid-operation reset,
// held start and random operands against a plain-arithmetic division model.
module tb_seq_divider;

  localparam int WIDTH = 32;

  logic       clock;
  logic       clear_n;
  logic [1:0] state_dbg;

  int checks   = 0;
  int failures = 0;

  logic [WIDTH-1:0] exp_q[$];
  logic             exp_dbz;

  seq_divider_if #(.WIDTH(WIDTH)) dif ();

  seq_divider #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clock     (clock),
    .clear_n   (clear_n),
    .bus       (dif.slave),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: truncating division via 64-bit signed arithmetic.
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                output logic [31:0] q, output logic [31:0] r, output logic z);
    longint sa, sb, tq, tr;
    logic [63:0] vq, vr;
    if (b == 32'd0) begin
      q = '1;
      r = a;
      z = 1'b1;
    end else begin
      if (s) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
      end else begin
        sa = {32'd0, a};
        sb = {32'd0, b};
      end
      tq = sa / sb;
      tr = sa % sb;
      vq = tq;
      vr = tr;
      q  = vq[31:0];
      r  = vr[31:0];
      z  = 1'b0;
    end
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_quotient"},  dif.quotient,    0);
    check({tag, "_remainder"}, dif.remainder,   0);
    check({tag, "_busy"},      dif.busy,        0);
    check({tag, "_done"},      dif.done,        0);
    check({tag, "_dbz"},       dif.div_by_zero, 0);
    check({tag, "_state"},     state_dbg,       0);
  endtask

  // driver: one operation, optional stray start pulse at cycle 'inject'
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s, input int inject);
    logic [31:0] eq, er;
    logic        ez;
    int          busy_n, done_n, exp_lat;
    model(a, b, s, eq, er, ez);
    exp_q.push_back(eq);
    exp_q.push_back(er);
    exp_dbz = ez;
    exp_lat = (b == 32'd0) ? 1 : WIDTH + 2;
    @(negedge clock);
    dif.start     = 1'b1;
    dif.dividend  = a;
    dif.divisor   = b;
    dif.signed_op = s;
    @(posedge clock);
    #1;
    dif.start     = 1'b0;
    dif.dividend  = $urandom;
    dif.divisor   = $urandom;
    dif.signed_op = 1'($urandom_range(0, 1));
    busy_n = 0;
    done_n = 0;
    for (int n = 1; n <= 60 && done_n == 0; n++) begin
      @(negedge clock);
      if (inject > 0 && n == inject) dif.start = 1'b1;
      if (inject > 0 && n == inject + 1) dif.start = 1'b0;
      if (dif.busy) busy_n++;
      if (dif.done) done_n = n;
    end
    dif.start = 1'b0;
    check("latency",     done_n, exp_lat);
    check("busy_cycles", busy_n, exp_lat - 1);
    check("quotient",    dif.quotient,    exp_q.pop_front());
    check("remainder",   dif.remainder,   exp_q.pop_front());
    check("div_by_zero", dif.div_by_zero, exp_dbz);
    @(negedge clock);
    check("done_pulse",  dif.done, 0);
    check("back_idle",   state_dbg, 0);
  endtask

  task automatic reset_mid_op();
    @(negedge clock);
    dif.start     = 1'b1;
    dif.dividend  = 32'h1234_5678;
    dif.divisor   = 32'd3;
    dif.signed_op = 1'b0;
    @(posedge clock);
    #1;
    dif.start = 1'b0;
    for (int n = 1; n < 20; n++) @(negedge clock);
    clear_n = 1'b0;
    #1;
    check_idle_outputs("abort");
    for (int n = 0; n < 3; n++) begin
      @(negedge clock);
      check("abort_no_done", dif.done, 0);
    end
    clear_n = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(negedge clock);
      check("abort_stays_idle", {dif.done, dif.busy}, 0);
    end
  endtask

  task automatic held_start();
    int first_n, second_n;
    first_n  = 0;
    second_n = 0;
    @(negedge clock);
    dif.start     = 1'b1;
    dif.dividend  = 32'd100;
    dif.divisor   = 32'd7;
    dif.signed_op = 1'b0;
    @(posedge clock);
    for (int n = 1; n <= 80 && second_n == 0; n++) begin
      @(negedge clock);
      if (dif.done && first_n == 0) first_n = n;
      else if (dif.done) second_n = n;
    end
    dif.start = 1'b0;
    check("held_first_done",  first_n,  WIDTH + 2);
    check("held_second_done", second_n, 2 * WIDTH + 5);
    check("held_quotient",    dif.quotient,  32'd14);
    check("held_remainder",   dif.remainder, 32'd2);
    @(negedge clock);
    @(negedge clock);
    check("held_idle", state_dbg, 0);
  endtask

  initial begin
    logic [31:0] a, b;
    logic        s;
    int          sel;
    dif.start     = 1'b0;
    dif.signed_op = 1'b0;
    dif.dividend  = '0;
    dif.divisor   = '0;
    clear_n       = 1'b0;
    repeat (3) @(negedge clock);
    check_idle_outputs("reset");
    clear_n = 1'b1;
    @(negedge clock);

    run_op(32'h0000_0054, 32'h0000_0006, 1'b1, 0);
    run_op(32'hFFFF_FFF9, 32'h0000_0002, 1'b1, 0);
    run_op(32'h0000_0007, 32'hFFFF_FFFE, 1'b1, 0);
    run_op(32'hFFFF_FFFF, 32'h0000_0010, 1'b0, 0);
    run_op(32'hFFFF_FFFF, 32'h0000_0010, 1'b1, 0);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
    run_op(32'h0000_0005, 32'h0000_0000, 1'b0, 0);
    run_op(32'h0000_0009, 32'h0000_0004, 1'b0, 0);
    run_op(32'hDEAD_BEEF, 32'h0000_1234, 1'b0, 10);
    reset_mid_op();
    run_op(32'h0001_0000, 32'h0000_0003, 1'b1, 0);
    held_start();

    for (int i = 0; i < 30; i++) begin
      sel = $urandom_range(0, 9);
      a   = (sel < 5) ? $urandom : 32'($urandom_range(0, 1000));
      if (sel == 0) b = 32'd0;
      else if (sel < 4) b = 32'($urandom_range(1, 20));
      else b = $urandom;
      if ($urandom_range(0, 1) == 1) a = -a;
      if (sel < 4 && $urandom_range(0, 1) == 1) b = -b;
      s = 1'($urandom_range(0, 1));
      run_op(a, b, s, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
